// File: rtl/cvxif_conv_cfg_unit.sv
// CV-X-IF front-end for the convolution accelerator: decodes custom-1 ops,
// holds speculative config writes until commit, launches and tracks the engine.
module cvxif_conv_cfg_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CH_WIDTH = 5,
    parameter logic [6:0]  OPCODE   = 7'h2B
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic                issue_rs1_valid_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic [XLEN-1:0]     cfg_w_addr_o,
    output logic [XLEN-1:0]     cfg_i_addr_o,
    output logic [XLEN-1:0]     cfg_r_addr_o,
    output logic [XLEN-1:0]     cfg_i_height_o,
    output logic [XLEN-1:0]     cfg_i_width_o,
    output logic [2:0]          cfg_w_height_o,
    output logic [2:0]          cfg_w_width_o,
    output logic [CH_WIDTH-1:0] cfg_i_channels_o,
    output logic [CH_WIDTH-1:0] cfg_w_channels_o,
    output logic [1:0]          cfg_padding_o,
    output logic                cfg_stride_o,
    output logic                start_o,
    input  logic                done_i,
    output logic                busy_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned GW = 9 + 2 * CH_WIDTH;

    typedef enum logic [1:0] {OP_SET, OP_START, OP_STAT} op_e;
    typedef enum logic {S_IDLE, S_RUN} state_e;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        op_e                 op;
        logic [2:0]          idx;
        logic [XLEN-1:0]     val;
        logic [4:0]          rd;
    } pend_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [4:0]          rd;
        logic [XLEN-1:0]     data;
    } res_t;

    pend_t           r_pend [DEPTH];
    res_t            r_res  [DEPTH];
    logic [PW-1:0]   r_p_rd, r_p_wr, r_r_rd, r_r_wr;
    logic [CW-1:0]   r_p_cnt, r_r_cnt;
    logic            r_start_pend, r_err, r_start;
    state_e          r_state, w_state_nxt;
    logic [XLEN-1:0] r_w_addr, r_i_addr, r_r_addr, r_i_h, r_i_w;
    logic [GW-1:0]   r_geom;

    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_opc, w_is_set, w_is_start, w_is_stat, w_match, w_acc;
    op_e         w_op;
    pend_t       w_head, w_new;
    res_t        w_rhead, w_res_new;
    logic        w_cmt_hit, w_cmt_bad, w_cmt_do, w_res_push, w_res_pop;
    logic        w_dec, w_full, w_stall, w_push, w_go, w_set_do;
    logic [CW-1:0] w_out;
    logic        w_unused;

    assign w_f3       = issue_instr_i[14:12];
    assign w_f7       = issue_instr_i[31:25];
    assign w_opc      = issue_instr_i[6:0] == OPCODE;
    assign w_is_set   = w_opc && (w_f3 == 3'b000);
    assign w_is_start = w_opc && (w_f3 == 3'b001);
    assign w_is_stat  = w_opc && (w_f3 == 3'b010);
    assign w_match    = w_is_set || w_is_start || w_is_stat;
    assign w_acc      = w_match && !(w_is_set && (w_f7 > 7'd5));
    assign w_unused   = ^issue_instr_i[24:15];

    always_comb begin
        w_op = OP_SET;
        unique case (1'b1)
            w_is_start: w_op = OP_START;
            w_is_stat:  w_op = OP_STAT;
            default:    w_op = OP_SET;
        endcase
    end

    assign w_new = '{id: issue_id_i, op: w_op, idx: w_f7[2:0],
                     val: issue_rs1_i, rd: issue_instr_i[11:7]};

    assign w_head     = r_pend[r_p_rd];
    assign w_cmt_hit  = commit_valid_i && (r_p_cnt != '0)
                        && (w_head.id == commit_id_i);
    assign w_cmt_bad  = commit_valid_i && !w_cmt_hit;
    assign w_cmt_do   = w_cmt_hit && !commit_kill_i;
    assign w_set_do   = w_cmt_do && (w_head.op == OP_SET);
    assign w_go       = w_cmt_do && (w_head.op == OP_START);
    assign w_res_push = w_cmt_do && (w_head.op == OP_STAT);
    assign w_res_pop  = result_valid_o && result_ready_i;
    assign w_res_new  = '{id: w_head.id, rd: w_head.rd,
                          data: XLEN'({r_err, busy_o})};

    // A slot freed this cycle (result pop or pending entry retired) admits an issue
    assign w_out   = r_p_cnt + r_r_cnt;
    assign w_dec   = w_res_pop || (w_cmt_hit && !w_res_push);
    assign w_full  = (w_out == CW'(DEPTH)) && !w_dec;
    assign w_stall = w_match && (w_full
                     || (w_is_set && !issue_rs1_valid_i)
                     || (w_is_start && (busy_o || r_start_pend)));

    assign issue_ready_o     = !w_stall;
    assign issue_accept_o    = issue_valid_i && w_acc;
    assign issue_writeback_o = issue_valid_i && w_is_stat;
    assign w_push            = issue_valid_i && issue_ready_o && w_acc;

    assign w_rhead        = r_res[r_r_rd];
    assign result_valid_o = r_r_cnt != '0;
    assign result_id_o    = w_rhead.id;
    assign result_data_o  = w_rhead.data;
    assign result_rd_o    = w_rhead.rd;
    assign result_we_o    = result_valid_o;

    always_ff @(posedge clk_i) begin
        if (w_push) r_pend[r_p_wr] <= w_new;
        if (w_res_push) r_res[r_r_wr] <= w_res_new;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_p_rd       <= '0;
            r_p_wr       <= '0;
            r_p_cnt      <= '0;
            r_r_rd       <= '0;
            r_r_wr       <= '0;
            r_r_cnt      <= '0;
            r_start_pend <= 1'b0;
            r_err        <= 1'b0;
            r_start      <= 1'b0;
        end else begin
            if (w_push) r_p_wr <= r_p_wr + PW'(1);
            if (w_cmt_hit) r_p_rd <= r_p_rd + PW'(1);
            r_p_cnt <= r_p_cnt + CW'(w_push) - CW'(w_cmt_hit);
            if (w_res_push) r_r_wr <= r_r_wr + PW'(1);
            if (w_res_pop) r_r_rd <= r_r_rd + PW'(1);
            r_r_cnt <= r_r_cnt + CW'(w_res_push) - CW'(w_res_pop);
            if (w_push && w_is_start) r_start_pend <= 1'b1;
            else if (w_cmt_hit && w_head.op == OP_START) r_start_pend <= 1'b0;
            if (w_cmt_bad) r_err <= 1'b1;
            r_start <= w_go;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_w_addr <= '0;
            r_i_addr <= '0;
            r_r_addr <= '0;
            r_i_h    <= '0;
            r_i_w    <= '0;
            r_geom   <= '0;
        end else if (w_set_do) begin
            unique case (w_head.idx)
                3'd0:    r_w_addr <= w_head.val;
                3'd1:    r_i_addr <= w_head.val;
                3'd2:    r_r_addr <= w_head.val;
                3'd3:    r_i_h    <= w_head.val;
                3'd4:    r_i_w    <= w_head.val;
                3'd5:    r_geom   <= w_head.val[GW-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_go) w_state_nxt = S_RUN;
            S_RUN:   if (done_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        if (r_state == S_RUN) busy_o = 1'b1;
    end

    assign start_o          = r_start;
    assign cfg_w_addr_o     = r_w_addr;
    assign cfg_i_addr_o     = r_i_addr;
    assign cfg_r_addr_o     = r_r_addr;
    assign cfg_i_height_o   = r_i_h;
    assign cfg_i_width_o    = r_i_w;
    assign cfg_w_height_o   = r_geom[2:0];
    assign cfg_w_width_o    = r_geom[5:3];
    assign cfg_i_channels_o = r_geom[6+:CH_WIDTH];
    assign cfg_w_channels_o = r_geom[6+CH_WIDTH+:CH_WIDTH];
    assign cfg_padding_o    = r_geom[6+2*CH_WIDTH+:2];
    assign cfg_stride_o     = r_geom[8+2*CH_WIDTH];

endmodule

// File: tb/tb_cvxif_conv_cfg_unit.sv
// Bench for cvxif_conv_cfg_unit: directed steps then random traffic,
// checked against a queue-based reference model.
module tb_cvxif_conv_cfg_unit;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i, issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [3:0]  issue_id_i;
    logic [31:0] issue_rs1_i;
    logic        issue_rs1_valid_i, issue_accept_o, issue_writeback_o;
    logic        commit_valid_i, commit_kill_i;
    logic [3:0]  commit_id_i;
    logic        result_valid_o, result_ready_i, result_we_o;
    logic [3:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic [31:0] cfg_w_addr_o, cfg_i_addr_o, cfg_r_addr_o;
    logic [31:0] cfg_i_height_o, cfg_i_width_o;
    logic [2:0]  cfg_w_height_o, cfg_w_width_o;
    logic [4:0]  cfg_i_channels_o, cfg_w_channels_o;
    logic [1:0]  cfg_padding_o;
    logic        cfg_stride_o, start_o, done_i, busy_o;

    always #5 clk = ~clk;

    cvxif_conv_cfg_unit dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs1_valid_i(issue_rs1_valid_i),
        .issue_accept_o(issue_accept_o),
        .issue_writeback_o(issue_writeback_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_data_o(result_data_o),
        .result_rd_o(result_rd_o), .result_we_o(result_we_o),
        .cfg_w_addr_o(cfg_w_addr_o), .cfg_i_addr_o(cfg_i_addr_o),
        .cfg_r_addr_o(cfg_r_addr_o), .cfg_i_height_o(cfg_i_height_o),
        .cfg_i_width_o(cfg_i_width_o), .cfg_w_height_o(cfg_w_height_o),
        .cfg_w_width_o(cfg_w_width_o),
        .cfg_i_channels_o(cfg_i_channels_o),
        .cfg_w_channels_o(cfg_w_channels_o),
        .cfg_padding_o(cfg_padding_o), .cfg_stride_o(cfg_stride_o),
        .start_o(start_o), .done_i(done_i), .busy_o(busy_o)
    );

    typedef struct {
        logic [3:0]  id;
        int          op;
        int          idx;
        logic [31:0] val;
        logic [4:0]  rd;
    } pe_t;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
    } re_t;

    pe_t         pq[$];
    re_t         rq[$];
    logic [31:0] m_cfg [6];
    bit          m_err, m_busy, m_start;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7,
                                       input logic [2:0] f3,
                                       input logic [4:0] rd,
                                       input logic [6:0] opc);
        return {f7, 5'd0, 5'd0, f3, rd, opc};
    endfunction

    task automatic model_reset();
        pq.delete();
        rq.delete();
        foreach (m_cfg[i]) m_cfg[i] = '0;
        m_err = 0;
        m_busy = 0;
        m_start = 0;
    endtask

    task automatic dec(input logic [31:0] ins, output bit m,
                       output int op, output int idx);
        m = 0;
        op = -1;
        idx = int'(ins[31:25]);
        if (ins[6:0] == 7'h2B && ins[14:12] <= 3'd2) begin
            m = 1;
            op = int'(ins[14:12]);
        end
    endtask

    function automatic bit head_hit();
        return commit_valid_i && pq.size() > 0 && pq[0].id == commit_id_i;
    endfunction

    function automatic bit ready_model(input bit m, input int op);
        int  total;
        bit  spend, hit, mv, frees, stall;
        total = pq.size() + rq.size();
        spend = 0;
        foreach (pq[i]) if (pq[i].op == 1) spend = 1;
        hit   = head_hit();
        mv    = hit && !commit_kill_i && pq[0].op == 2;
        frees = (rq.size() > 0 && result_ready_i) || (hit && !mv);
        stall = (total == 4 && !frees)
              || (op == 0 && !issue_rs1_valid_i)
              || (op == 1 && (m_busy || spend));
        return !m || !stall;
    endfunction

    task automatic model_step(input bit fire, input bit acc, input int op,
                              input int idx);
        bit  pop, nbusy, nerr, nstart, rpush;
        re_t r;
        pe_t e;
        pop    = rq.size() > 0 && result_ready_i;
        nbusy  = m_busy;
        nerr   = m_err;
        nstart = 0;
        rpush  = 0;
        if (m_busy && done_i) nbusy = 0;
        if (commit_valid_i) begin
            if (head_hit()) begin
                e = pq.pop_front();
                if (!commit_kill_i) begin
                    if (e.op == 0) m_cfg[e.idx] = e.val;
                    if (e.op == 1) begin
                        nstart = 1;
                        nbusy = 1;
                    end
                    if (e.op == 2) begin
                        r = '{id: e.id, rd: e.rd,
                              data: {30'd0, m_err, m_busy}};
                        rpush = 1;
                    end
                end
            end else nerr = 1;
        end
        if (pop) void'(rq.pop_front());
        if (rpush) rq.push_back(r);
        if (fire && acc)
            pq.push_back('{id: issue_id_i, op: op, idx: idx,
                           val: issue_rs1_i, rd: issue_instr_i[11:7]});
        m_err = nerr;
        m_busy = nbusy;
        m_start = nstart;
    endtask

    task automatic check_regs();
        logic [31:0] g;
        g = m_cfg[5];
        chk("cfg_w_addr", cfg_w_addr_o, m_cfg[0]);
        chk("cfg_i_addr", cfg_i_addr_o, m_cfg[1]);
        chk("cfg_r_addr", cfg_r_addr_o, m_cfg[2]);
        chk("cfg_i_height", cfg_i_height_o, m_cfg[3]);
        chk("cfg_i_width", cfg_i_width_o, m_cfg[4]);
        chk("cfg_w_height", 32'(cfg_w_height_o), 32'(g[2:0]));
        chk("cfg_w_width", 32'(cfg_w_width_o), 32'(g[5:3]));
        chk("cfg_i_ch", 32'(cfg_i_channels_o), 32'(g[10:6]));
        chk("cfg_w_ch", 32'(cfg_w_channels_o), 32'(g[15:11]));
        chk("cfg_padding", 32'(cfg_padding_o), 32'(g[17:16]));
        chk("cfg_stride", 32'(cfg_stride_o), 32'(g[18]));
        chk("start_o", 32'(start_o), 32'(m_start));
        chk("busy_o", 32'(busy_o), 32'(m_busy));
        chk("result_valid", 32'(result_valid_o), 32'(rq.size() > 0));
        if (rq.size() > 0) begin
            chk("result_id", 32'(result_id_o), 32'(rq[0].id));
            chk("result_data", result_data_o, rq[0].data);
            chk("result_rd", 32'(result_rd_o), 32'(rq[0].rd));
            chk("result_we", 32'(result_we_o), 32'(1));
        end
    endtask

    task automatic tick();
        bit m, acc, rdy;
        int op, idx;
        #1;
        dec(issue_instr_i, m, op, idx);
        acc = m && !(op == 0 && idx > 5);
        rdy = ready_model(m, op);
        chk("issue_ready", 32'(issue_ready_o), 32'(rdy));
        if (issue_valid_i) begin
            chk("issue_accept", 32'(issue_accept_o), 32'(acc));
            chk("issue_wb", 32'(issue_writeback_o), 32'(m && op == 2));
        end
        @(posedge clk);
        model_step(issue_valid_i && rdy, acc, op, idx);
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid_i = 0;
        issue_instr_i = '0;
        issue_id_i = '0;
        issue_rs1_i = '0;
        issue_rs1_valid_i = 0;
        commit_valid_i = 0;
        commit_id_i = '0;
        commit_kill_i = 0;
        done_i = 0;
    endtask

    task automatic iss(input logic [31:0] ins, input logic [3:0] id,
                       input logic [31:0] rs1);
        idle();
        issue_valid_i = 1;
        issue_instr_i = ins;
        issue_id_i = id;
        issue_rs1_i = rs1;
        issue_rs1_valid_i = 1;
    endtask

    task automatic cmt(input logic [3:0] id, input bit kill);
        idle();
        commit_valid_i = 1;
        commit_id_i = id;
        commit_kill_i = kill;
    endtask

    logic [31:0] i_start, i_stat9, i_stat10, i_stat4, w_save;
    logic [3:0]  nid;

    initial begin
        i_start  = mk(7'd0, 3'b001, 5'd0, 7'h2B);
        i_stat9  = mk(7'd0, 3'b010, 5'd9, 7'h2B);
        i_stat10 = mk(7'd0, 3'b010, 5'd10, 7'h2B);
        i_stat4  = mk(7'd0, 3'b010, 5'd4, 7'h2B);
        rst_ni = 0;
        result_ready_i = 0;
        idle();
        model_reset();
        #3;
        check_regs();
        @(negedge clk);
        rst_ni = 1;
        tick();

        // SETREG idx0 then commit
        iss(mk(7'd0, 3'b000, 5'd0, 7'h2B), 4'd3, 32'h8000_1000);
        tick();
        cmt(4'd3, 0);
        tick();
        chk("dir_w_addr", cfg_w_addr_o, 32'h8000_1000);

        // geometry word
        iss(mk(7'd5, 3'b000, 5'd0, 7'h2B), 4'd4, 32'h0004_2C9B);
        tick();
        cmt(4'd4, 0);
        tick();
        chk("dir_w_h", 32'(cfg_w_height_o), 32'd3);
        chk("dir_w_w", 32'(cfg_w_width_o), 32'd3);
        chk("dir_i_ch", 32'(cfg_i_channels_o), 32'd18);
        chk("dir_w_ch", 32'(cfg_w_channels_o), 32'd5);
        chk("dir_pad", 32'(cfg_padding_o), 32'd0);
        chk("dir_stride", 32'(cfg_stride_o), 32'd1);

        // killed SETREG
        iss(mk(7'd1, 3'b000, 5'd0, 7'h2B), 4'd1, 32'h1234_5678);
        tick();
        cmt(4'd1, 1);
        tick();
        chk("dir_kill_cfg", cfg_i_addr_o, 32'd0);
        chk("dir_kill_empty", 32'(pq.size() + rq.size()), 32'd0);

        // START, STATUS, second START stall until done
        iss(i_start, 4'd4, '0);
        tick();
        cmt(4'd4, 0);
        tick();
        chk("dir_start_pulse", 32'(start_o), 32'd1);
        chk("dir_busy", 32'(busy_o), 32'd1);
        idle();
        tick();
        chk("dir_start_once", 32'(start_o), 32'd0);
        iss(i_stat9, 4'd5, '0);
        tick();
        cmt(4'd5, 0);
        tick();
        chk("dir_stat_busy", result_data_o, 32'h1);
        chk("dir_stat_rd", 32'(result_rd_o), 32'd9);
        result_ready_i = 1;
        idle();
        tick();
        iss(i_start, 4'd6, '0);
        #1;
        chk("dir_start2_stall", 32'(issue_ready_o), 32'd0);
        done_i = 1;
        tick();
        done_i = 0;
        #1;
        chk("dir_start2_open", 32'(issue_ready_o), 32'd1);
        tick();
        cmt(4'd6, 1);
        tick();
        result_ready_i = 0;
        iss(i_stat10, 4'd7, '0);
        tick();
        cmt(4'd7, 0);
        tick();
        chk("dir_stat_idle", result_data_o, 32'h0);
        chk("dir_stat_rd10", 32'(result_rd_o), 32'd10);
        result_ready_i = 1;
        idle();
        tick();

        // outstanding limit
        result_ready_i = 0;
        for (int i = 8; i < 12; i++) begin
            iss(i_stat9, 4'(i), '0);
            tick();
        end
        for (int i = 8; i < 12; i++) begin
            cmt(4'(i), 0);
            tick();
        end
        iss(i_stat9, 4'd12, '0);
        #1;
        chk("dir_full_stall", 32'(issue_ready_o), 32'd0);
        tick();
        result_ready_i = 1;
        #1;
        chk("dir_pop_reopen", 32'(issue_ready_o), 32'd1);
        tick();
        cmt(4'd12, 0);
        tick();
        idle();
        for (int i = 0; i < 5; i++) tick();

        // bad commit sets sticky err
        result_ready_i = 0;
        w_save = 32'hCAFE_0001;
        iss(mk(7'd1, 3'b000, 5'd0, 7'h2B), 4'd2, w_save);
        tick();
        cmt(4'd7, 0);
        tick();
        cmt(4'd2, 0);
        tick();
        iss(i_stat4, 4'd3, '0);
        tick();
        cmt(4'd3, 0);
        tick();
        chk("dir_err_bit", result_data_o, 32'h2);

        // asynchronous reset mid-queue
        iss(i_start, 4'd4, '0);
        tick();
        cmt(4'd4, 0);
        tick();
        iss(i_stat4, 4'd5, '0);
        tick();
        idle();
        #2;
        rst_ni = 0;
        #1;
        model_reset();
        chk("rst_valid", 32'(result_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_cfg", cfg_i_addr_o, 32'd0);
        check_regs();
        @(negedge clk);
        rst_ni = 1;
        tick();

        // random traffic
        nid = '0;
        for (int c = 0; c < 400; c++) begin
            int k;
            logic [6:0] f7;
            logic [2:0] f3;
            logic [6:0] opc;
            idle();
            k = int'($urandom_range(0, 9));
            opc = 7'h2B;
            f7 = 7'd0;
            f3 = 3'b010;
            if (k == 0) opc = 7'h0B;
            else if (k == 1) f3 = 3'($urandom_range(3, 7));
            else if (k <= 5) begin
                f3 = 3'b000;
                f7 = 7'($urandom_range(0, 7));
            end else if (k <= 7) f3 = 3'b001;
            issue_valid_i = $urandom_range(0, 9) < 7;
            issue_instr_i = mk(f7, f3, 5'($urandom), opc);
            issue_id_i = nid;
            issue_rs1_i = $urandom;
            issue_rs1_valid_i = $urandom_range(0, 9) < 8;
            nid = nid + 4'd1;
            if ($urandom_range(0, 1) == 1) begin
                commit_valid_i = 1;
                commit_kill_i = $urandom_range(0, 3) == 0;
                if (pq.size() > 0 && $urandom_range(0, 9) != 0)
                    commit_id_i = pq[0].id;
                else
                    commit_id_i = 4'($urandom);
            end
            result_ready_i = $urandom_range(0, 9) < 6;
            done_i = $urandom_range(0, 4) == 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
